fpga_adc_regbank: RTL
=====================

FPGA_ADC_REGBANK -- requirements
Module: fpga_adc_regbank

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6: byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
REQ-003 Parameter NUM_RW_REGS, default 4: count of read/write control registers, 1..8.
REQ-004 Parameter NUM_CH, default 2: ADC sample channels, 1..8.
REQ-005 Parameter SAMPLE_W, default 16: sample width, 1..32.
REQ-006 S_AXI_ACLK in 1: single clock; all logic on the rising edge.
REQ-007 S_AXI_ARESETN in 1: synchronous, active-low reset.
REQ-008 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: AXI4-Lite write channels; AWPROT is ignored.
REQ-009 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: AXI4-Lite read channels; ARPROT is ignored.
REQ-010 ctrl_regs out NUM_RW_REGS*32: flat copy of the RW registers; register k occupies bits [32k+31:32k].
REQ-011 sample_data in NUM_CH*SAMPLE_W: per-channel sample words.
REQ-012 sample_valid in NUM_CH: single-cycle per-channel capture strobes.

Function
REQ-013 The address map SHALL be: words 0..NUM_RW_REGS-1 RW; word NUM_RW_REGS STATUS (RO); words NUM_RW_REGS+1+k CHk_DATA (RO, zero-extended); all higher words are unmapped.
REQ-014 Write: AWREADY and WREADY SHALL pulse together for one cycle when AWVALID and WVALID are both high and BVALID is low.
REQ-015 The register update SHALL take effect in the cycle after the handshake, per byte lane enabled by WSTRB, and BVALID SHALL assert in that same cycle and hold until BREADY.
REQ-016 A write to an RW register SHALL return BRESP OKAY; a write to an RO or unmapped word SHALL change nothing and return BRESP SLVERR.
REQ-017 Read: ARREADY SHALL pulse for one cycle when ARVALID is high and RVALID is low; RVALID SHALL assert the next cycle with stable RDATA/RRESP held until RREADY.
REQ-018 An unmapped read SHALL return RDATA 0 with RRESP SLVERR; all mapped reads SHALL return OKAY.
REQ-019 Capture: sample_valid[k] SHALL latch the channel-k sample into CHk_DATA and set ready[k], visible in the following cycle.
REQ-020 STATUS bits [NUM_CH-1:0] SHALL be ready[]; bits [16+NUM_CH-1:16] SHALL be overrun[]; all other bits read 0.
REQ-021 sample_valid[k] while ready[k]=1 SHALL overwrite CHk_DATA and set overrun[k] (sticky).
REQ-022 The ARREADY handshake of a CHk_DATA read SHALL clear ready[k]; the ARREADY handshake of a STATUS read SHALL clear all overrun[]. The returned data SHALL be the pre-clear value.
REQ-023 A CHk_DATA read handshake coinciding with sample_valid[k] SHALL return the old sample, leave ready[k]=1, and SHALL NOT set overrun[k].
REQ-024 A STATUS read handshake coinciding with a new overrun event SHALL leave that overrun bit set (set wins over clear).
REQ-025 The read and write channels SHALL operate independently and concurrently; each SHALL have at most one outstanding transaction.

Reset
REQ-026 While S_AXI_ARESETN=0 at a clock edge, all READY/VALID outputs, BRESP, RRESP, RDATA, ctrl_regs, CHk_DATA, ready[], overrun[] and irq SHALL be 0 the next cycle.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no response; samples arriving during reset SHALL be dropped.

Configuration
REQ-028 Macro FPGA_ADC_REGBANK_IRQ_EN defined: the block SHALL add output irq (1 bit) and an RW register IRQ_MASK at word NUM_RW_REGS+1+NUM_CH (bit k enables ready[k], bit 16+k enables overrun[k]).
REQ-029 With the macro defined, irq SHALL be the registered OR of (STATUS & IRQ_MASK), updating one cycle after any STATUS or mask change.
REQ-030 Macro undefined: no irq port and no IRQ_MASK register; word NUM_RW_REGS+1+NUM_CH is unmapped.

Verification
REQ-031 Write 0x1,0x2,0x3,0x4 to words 0..3, WSTRB=0xF, then read back -> RDATA 0x1..0x4, all OKAY, ctrl_regs = 0x00000004_00000003_00000002_00000001.
REQ-032 Write 0xAABBCCDD to word 0 with WSTRB=0x5 over value 0x11223344 -> read 0x11BB33DD.
REQ-033 sample_valid[0] with 0x1234 -> STATUS=0x00000001; read CH0_DATA=0x00001234; STATUS then reads 0x0.
REQ-034 Two CH1 strobes without a read -> STATUS=0x00020002; read STATUS clears bit 17; a new overrun event in the STATUS-read handshake cycle keeps bit 17=1.
REQ-035 Write to STATUS and read word 15 -> BRESP=SLVERR, RDATA=0 with RRESP=SLVERR, no state change.
REQ-036 IRQ_EN defined: IRQ_MASK=0x1, CH0 strobe -> irq=1 within 2 cycles; CH0_DATA read -> irq=0 the cycle after the clear; reset asserted mid-write -> BVALID never asserts.

Source files
------------

// File: rtl/fpga_adc_regbank_if.sv
// Purpose : AXI4-Lite slave bundle (write address/data/response, read address/data).
// Latency : n/a, wiring only.
// Backpressure: plain AXI valid/ready on every channel.
// Ports   : slave modport for the register bank, master modport for the bus driver.
interface fpga_adc_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/fpga_adc_regbank.sv
// Purpose : AXI4-Lite register bank: RW control regs, STATUS, per-channel ADC sample capture.
// Latency : AW/W/AR ready one cycle after valid; B/R response one cycle after the handshake.
// Backpressure: one outstanding write and one outstanding read; ready withheld while B/R valid.
// Ports   : S_AXI_ACLK, S_AXI_ARESETN (sync, active low), s_axi (slave bundle),
//           ctrl_regs (flat RW regs), sample_data/sample_valid (capture), irq (optional).
// Option  : FPGA_ADC_REGBANK_IRQ_EN adds IRQ_MASK at word NUM_RW_REGS+1+NUM_CH and the irq output.
module fpga_adc_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW_REGS        = 4,
  parameter int NUM_CH             = 2,
  parameter int SAMPLE_W           = 16
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  fpga_adc_regbank_if.slave            s_axi,
  output logic [NUM_RW_REGS*32-1:0]    ctrl_regs,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  input  logic [NUM_CH-1:0]            sample_valid
`ifdef FPGA_ADC_REGBANK_IRQ_EN
  ,
  output logic                         irq
`endif
);
  localparam int STATUS_IDX = NUM_RW_REGS;
  localparam int CH_BASE    = NUM_RW_REGS + 1;
  localparam int MASK_IDX   = CH_BASE + NUM_CH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          awready_q, awready_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]                   ctrl_q [NUM_RW_REGS];
  logic [31:0]                   ctrl_d [NUM_RW_REGS];
  logic [SAMPLE_W-1:0]           ch_q [NUM_CH];
  logic [SAMPLE_W-1:0]           ch_d [NUM_CH];
  logic [NUM_CH-1:0]             ready_q, ready_d;
  logic [NUM_CH-1:0]             ovr_q, ovr_d;
`ifdef FPGA_ADC_REGBANK_IRQ_EN
  logic [31:0]                   mask_q, mask_d;
  logic                          irq_q, irq_d;
`endif

  logic        wr_hs, rd_hs, wr_ok, rd_err;
  logic [31:0] wr_word, rd_word, rd_mux, status;
  logic        unused_sigs;

  assign wr_word = 32'(s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign rd_word = 32'(s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  // AWREADY and WREADY are the same pulse, so one term covers both channels.
  assign wr_hs   = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_hs   = arready_q & s_axi.S_AXI_ARVALID;
  assign unused_sigs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    status = '0;
    status[NUM_CH-1:0]  = ready_q;
    status[16 +: NUM_CH] = ovr_q;
  end

  // Write decode: only RW words (and IRQ_MASK when present) accept data.
  always_comb begin
    wr_ok = 1'b0;
    for (int k = 0; k < NUM_RW_REGS; k++)
      if (wr_word == 32'(k)) wr_ok = 1'b1;
`ifdef FPGA_ADC_REGBANK_IRQ_EN
    if (wr_word == 32'(MASK_IDX)) wr_ok = 1'b1;
`endif
  end

  // Read mux: unmapped words fall through to 0 / SLVERR.
  always_comb begin
    rd_mux = '0;
    rd_err = 1'b1;
    for (int k = 0; k < NUM_RW_REGS; k++)
      if (rd_word == 32'(k)) begin rd_mux = ctrl_q[k]; rd_err = 1'b0; end
    if (rd_word == 32'(STATUS_IDX)) begin rd_mux = status; rd_err = 1'b0; end
    for (int k = 0; k < NUM_CH; k++)
      if (rd_word == 32'(CH_BASE + k)) begin rd_mux = 32'(ch_q[k]); rd_err = 1'b0; end
`ifdef FPGA_ADC_REGBANK_IRQ_EN
    if (rd_word == 32'(MASK_IDX)) begin rd_mux = mask_q; rd_err = 1'b0; end
`endif
  end

  always_comb begin
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    ch_d      = ch_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
`ifdef FPGA_ADC_REGBANK_IRQ_EN
    mask_d    = mask_q;
    irq_d     = |(status & mask_q);
`endif

    // Write channel
    if (!awready_q && !bvalid_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID)
      awready_d = 1'b1;
    if (bvalid_q && s_axi.S_AXI_BREADY)
      bvalid_d = 1'b0;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int k = 0; k < NUM_RW_REGS; k++)
        if (wr_word == 32'(k))
          for (int b = 0; b < 4; b++)
            if (s_axi.S_AXI_WSTRB[b]) ctrl_d[k][8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
`ifdef FPGA_ADC_REGBANK_IRQ_EN
      if (wr_word == 32'(MASK_IDX))
        for (int b = 0; b < 4; b++)
          if (s_axi.S_AXI_WSTRB[b]) mask_d[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
`endif
    end

    // Read channel
    if (!arready_q && !rvalid_q && s_axi.S_AXI_ARVALID)
      arready_d = 1'b1;
    if (rvalid_q && s_axi.S_AXI_RREADY)
      rvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      if (rd_word == 32'(STATUS_IDX)) ovr_d = '0;
    end

    // Capture. Read-clears are applied first so a coincident strobe wins;
    // a strobe colliding with its own data read is a hand-off, not an overrun.
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_hs && rd_word == 32'(CH_BASE + k)) begin
        ready_d[k] = 1'b0;
        if (sample_valid[k]) begin
          ch_d[k]    = sample_data[k*SAMPLE_W +: SAMPLE_W];
          ready_d[k] = 1'b1;
        end
      end else if (sample_valid[k]) begin
        ch_d[k]    = sample_data[k*SAMPLE_W +: SAMPLE_W];
        ready_d[k] = 1'b1;
        if (ready_q[k]) ovr_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      ctrl_q    <= '{default: '0};
      ch_q      <= '{default: '0};
      ready_q   <= '0;
      ovr_q     <= '0;
`ifdef FPGA_ADC_REGBANK_IRQ_EN
      mask_q    <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      ch_q      <= ch_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
`ifdef FPGA_ADC_REGBANK_IRQ_EN
      mask_q    <= mask_d;
      irq_q     <= irq_d;
`endif
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
`ifdef FPGA_ADC_REGBANK_IRQ_EN
  assign irq = irq_q;
`endif

  always_comb begin
    ctrl_regs = '0;
    for (int k = 0; k < NUM_RW_REGS; k++) ctrl_regs[32*k +: 32] = ctrl_q[k];
  end
endmodule
